lc3_pipeline_ctrl: RTL and testbench
====================================

# lc3_pipeline_ctrl

Central sequencing controller for the five-stage LC3 pipeline (Fetch, Decode, Execute, MemAccess, Writeback). It generates every stage enable. It stalls the pipe for instruction-memory wait states and multi-phase data-memory accesses, and resolves BR/JMP control flow with a pipeline refill. It also drives the ALU and memory forwarding selects. It connects to the stages through the `Controller` modport of `LC3_if`.

## Interface
- No parameters.
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `complete_instr`  in  1  instruction memory has valid `Instr_dout` this cycle.
- `complete_data`  in  1  data memory finished the current phase.
- `IR`  in  16  instruction in Decode.
- `IR_Exec`  in  16  instruction in Execute (registered by Execute).
- `Instr_dout`  in  16  fetched word. Unused except for lint; kept for modport compatibility.
- `NZP`  in  3  branch condition field from Execute.
- `psr`  in  3  current N/Z/P condition codes from Writeback.
- `enable_updatePC`, `enable_fetch`, `enable_decode`, `enable_execute`, `enable_writeback`  out  1 each  stage enables.
- `bypass_alu_1`, `bypass_alu_2`, `bypass_mem_1`, `bypass_mem_2`  out  1 each  operand forwarding selects.
- `mem_state`  out  2  0 = read, 1 = indirect-address read, 2 = write, 3 = idle.
- `br_taken`  out  1  PC loads branch target this cycle.

## Operation
- FSM states: FILL, RUN, DETECT_MEM, MEM_IND, MEM_RD, MEM_WR, BR_EXEC.
- **Reset.** All outputs are 0, except `mem_state` = 3. The state becomes FILL and the fill count is 0.
- **FILL.** The count runs 0→3. Enables are cumulative:
  - count 0: updatePC and fetch.
  - count 1: adds decode.
  - count 2: adds execute.
  - count 3: adds writeback. The next state is RUN.
- **Instruction-memory stall.** In FILL and RUN, if `complete_instr` = 0, all enables are 0. The count and state hold.
- **RUN.** All enables are 1, subject to the `complete_instr` gate.
- **Memory op in Execute.** If `IR_Exec` opcode is LD(0010), LDR(0110), LDI(1010), ST(0011), STR(0111) or STI(1011), all enables are 0 this cycle and the next state is DETECT_MEM.
- **DETECT_MEM.**
  - LDI/STI go to MEM_IND.
  - Loads go to MEM_RD.
  - Stores go to MEM_WR.
- **Memory states.** `mem_state` is 1 in MEM_IND, 0 in MEM_RD and 2 in MEM_WR. All enables are 0 while `complete_data` = 0.
- **MEM_IND exit.** When `complete_data` = 1, go to MEM_RD (LDI) or MEM_WR (STI).
- **MEM_RD exit.** When `complete_data` = 1, all five enables are 1 and the next state is RUN.
- **MEM_WR exit.** When `complete_data` = 1, the enables except writeback are 1 and the next state is RUN.
- **Control op in Decode.** In RUN, if `IR` opcode is BR(0000) or JMP(1100), updatePC, fetch and decode are 0 this cycle, and the next state is BR_EXEC. A memory op in `IR_Exec` takes priority.
- **BR_EXEC.**
  - Execute and writeback are enabled, and updatePC = 1.
  - `br_taken` = |(`NZP` & `psr`) for BR, and 1 for JMP.
  - The next state is FILL with count 1. Fetch restarts from the resolved PC and stale decode is discarded.
- **`bypass_alu_1`.** Set when all of the following hold (combinational):
  - `IR_Exec` is ADD(0001), AND(0101), NOT(1001) or LEA(1110).
  - `IR` reads SR1 = `IR[8:6]`. Readers are ADD, AND, NOT, LDR, STR, JMP.
  - `IR[8:6]` = `IR_Exec[11:9]`.
- **`bypass_alu_2`.** Same condition against the second operand:
  - `IR[2:0]` for ADD/AND with `IR[5]` = 0.
  - `IR[11:9]` for ST/STR/STI.
- **`bypass_mem_1` / `bypass_mem_2`.** Same matching against a load in `IR_Exec`. These are asserted only in the MEM_RD exit cycle.
- **Reset priority.** `reset` mid-operation overrides every state and returns outputs to their reset values on the next edge.

## Timing
- Reset release to first fetch enable: 0 cycles.
- Reset release to all enables high: 4 cycles, with no stalls.
- Minimum memory stall: 1 detect cycle plus 1 cycle per phase.
  - LD: 2 dead cycles.
  - LDI: 3 dead cycles.
- Branch penalty: 1 bubble cycle, 1 BR_EXEC cycle and a 3-cycle refill.
- All outputs are combinational from the registered state, the fill count and the inputs.
- Outputs are glitch-tolerant: they are sampled by the stages on the next edge only.

## Structure
- Package `lc3_pkg` holds:
  - opcode enum `lc3_op_e`.
  - `mem_state` encodings (`MEM_RD` = 0, `MEM_IND` = 1, `MEM_WR` = 2, `MEM_IDLE` = 3).
  - FSM state enum.
  - helper functions `is_alu`, `is_load`, `is_store`, `reads_sr1`, `reads_sr2`.
- Sub-module `lc3_bypass_unit` is purely combinational. It takes `IR`, `IR_Exec` and a mem-exit strobe, and produces the four bypass bits.

## Test plan
- **Reset and fill.** Reset for 2 cycles, then release with `complete_instr` = 1. Enables ramp {updatePC, fetch} → +decode → +execute → +writeback over cycles 0–3. `mem_state` = 3 throughout.
- **LDI with wait states.** `IR_Exec` = 0xA5FF in RUN, with `complete_data` low for 2 cycles in each phase. Sequence:
  - 1 detect cycle.
  - `mem_state` = 1 for 3 cycles.
  - `mem_state` = 0 for 3 cycles.
  - Exit cycle with all enables = 1.
- **Branch taken and not taken.** `IR` = 0x0E05 (BRnzp):
  - bubble cycle: fetch = 0.
  - BR_EXEC with `NZP` = 3'b111, `psr` = 3'b010: `br_taken` = 1.
  - Repeat with `NZP` = 3'b100: `br_taken` = 0.
  - Both cases then refill from count 1.
- **ALU forwarding.** `IR_Exec` = 0x1261 (ADD R1,R1,#1) with `IR` = 0x1442 (ADD R2,R1,R2). Result: `bypass_alu_1` = 1, `bypass_alu_2` = 0.
- **Memory forwarding and mid-operation reset.**
  - LDR R3 in Execute with `IR` = ADD R4,R3,R3. In the MEM_RD exit cycle, `bypass_mem_1` = `bypass_mem_2` = 1.
  - Assert `reset` during MEM_WR. Next cycle: all outputs 0 and `mem_state` = 3.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types and decode helpers for the LC3 pipeline controller.
//   lc3_op_e      - 4-bit opcode field IR[15:12]
//   MEM_*         - data-memory phase encodings driven on mem_state
//   ctrl_state_e  - sequencing FSM states
//   is_alu / is_load / is_store / is_indirect / is_mem / is_ctrl
//   reads_sr1 / reads_sr2 - which source-register fields a Decode op reads
package lc3_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000, OP_ADD  = 4'b0001, OP_LD   = 4'b0010, OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100, OP_AND  = 4'b0101, OP_LDR  = 4'b0110, OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000, OP_NOT  = 4'b1001, OP_LDI  = 4'b1010, OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100, OP_RES  = 4'b1101, OP_LEA  = 4'b1110, OP_TRAP = 4'b1111
  } lc3_op_e;

  localparam logic [1:0] MEM_RD   = 2'd0;
  localparam logic [1:0] MEM_IND  = 2'd1;
  localparam logic [1:0] MEM_WR   = 2'd2;
  localparam logic [1:0] MEM_IDLE = 2'd3;

  typedef enum logic [2:0] {
    S_FILL, S_RUN, S_DETECT_MEM, S_MEM_IND, S_MEM_RD, S_MEM_WR, S_BR_EXEC
  } ctrl_state_e;

  function automatic logic is_alu(input lc3_op_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
  endfunction

  function automatic logic is_load(input lc3_op_e op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_store(input lc3_op_e op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic logic is_indirect(input lc3_op_e op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  function automatic logic is_mem(input lc3_op_e op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic is_ctrl(input lc3_op_e op);
    return (op == OP_BR) || (op == OP_JMP);
  endfunction

  function automatic logic reads_sr1(input lc3_op_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) ||
           (op == OP_LDR) || (op == OP_STR) || (op == OP_JMP);
  endfunction

  // imm_flag is IR[5]: ADD/AND only use a second register when it is clear.
  function automatic logic reads_sr2(input lc3_op_e op, input logic imm_flag);
    return (((op == OP_ADD) || (op == OP_AND)) && !imm_flag) || is_store(op);
  endfunction

endpackage

// File: rtl/lc3_pipeline_ctrl_bypass.sv
// lc3_bypass_unit: combinational operand-forwarding selects.
//   IR        in  16  instruction in Decode
//   IR_Exec   in  16  instruction in Execute
//   mem_exit  in  1   strobe: the load in Execute completes this cycle
//   bypass_alu_1/2, bypass_mem_1/2  out  forwarding selects for SR1 / SR2
module lc3_bypass_unit
  import lc3_pkg::*;
(
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic        mem_exit,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2
);

  lc3_op_e    id_op, ex_op;
  logic [2:0] ex_dr, sr2_sel;
  logic       sr1_match, sr2_match;
  logic       unused_bits;

  assign id_op = lc3_op_e'(IR[15:12]);
  assign ex_op = lc3_op_e'(IR_Exec[15:12]);
  assign ex_dr = IR_Exec[11:9];

  // Stores carry their data register in the DR slot, not in IR[2:0].
  assign sr2_sel   = is_store(id_op) ? IR[11:9] : IR[2:0];
  assign sr1_match = reads_sr1(id_op) && (IR[8:6] == ex_dr);
  assign sr2_match = reads_sr2(id_op, IR[5]) && (sr2_sel == ex_dr);

  assign bypass_alu_1 = is_alu(ex_op) && sr1_match;
  assign bypass_alu_2 = is_alu(ex_op) && sr2_match;
  assign bypass_mem_1 = mem_exit && is_load(ex_op) && sr1_match;
  assign bypass_mem_2 = mem_exit && is_load(ex_op) && sr2_match;

  assign unused_bits = ^{IR[4:3], IR_Exec[8:0]};

endmodule

// File: rtl/lc3_pipeline_ctrl.sv
// lc3_pipeline_ctrl: sequencing controller for the 5-stage LC3 pipeline.
//   clk, reset (sync, active-high)
//   complete_instr / complete_data  memory handshakes
//   IR, IR_Exec, Instr_dout, NZP, psr  instruction and condition inputs
//   enable_updatePC/fetch/decode/execute/writeback  stage enables
//   bypass_alu_1/2, bypass_mem_1/2  forwarding selects
//   mem_state  data-memory phase (3 = idle), br_taken  PC loads target
// All outputs are combinational from state_q, fill_cnt_q and the inputs.
module lc3_pipeline_ctrl
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [15:0] Instr_dout,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state,
  output logic        br_taken
);

  ctrl_state_e state_q, state_d;
  logic [1:0]  fill_cnt_q, fill_cnt_d;
  logic        en_pc, en_fetch, en_dec, en_exe, en_wb, br, mem_exit;
  logic [1:0]  mem_st;
  logic        alu_1, alu_2, mem_1, mem_2;
  lc3_op_e     id_op, ex_op;
  logic        unused_instr;

  assign id_op = lc3_op_e'(IR[15:12]);
  assign ex_op = lc3_op_e'(IR_Exec[15:12]);
  assign unused_instr = ^Instr_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FILL;
      fill_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    en_pc      = 1'b0;
    en_fetch   = 1'b0;
    en_dec     = 1'b0;
    en_exe     = 1'b0;
    en_wb      = 1'b0;
    br         = 1'b0;
    mem_exit   = 1'b0;
    mem_st     = MEM_IDLE;
    case (state_q)
      S_FILL: begin
        // Enables accumulate as valid instructions reach each stage.
        if (complete_instr) begin
          en_pc    = 1'b1;
          en_fetch = 1'b1;
          en_dec   = (fill_cnt_q >= 2'd1);
          en_exe   = (fill_cnt_q >= 2'd2);
          en_wb    = (fill_cnt_q == 2'd3);
          if (fill_cnt_q == 2'd3) state_d = S_RUN;
          else                    fill_cnt_d = fill_cnt_q + 2'd1;
        end
      end
      S_RUN: begin
        // Memory op in Execute freezes the whole pipe, even over a fetch wait.
        if (is_mem(ex_op)) begin
          state_d = S_DETECT_MEM;
        end else if (complete_instr) begin
          en_exe = 1'b1;
          en_wb  = 1'b1;
          // Control op: let it advance into Execute, hold the front end.
          if (is_ctrl(id_op)) begin
            state_d = S_BR_EXEC;
          end else begin
            en_pc    = 1'b1;
            en_fetch = 1'b1;
            en_dec   = 1'b1;
          end
        end
      end
      S_DETECT_MEM: begin
        if (is_indirect(ex_op))  state_d = S_MEM_IND;
        else if (is_load(ex_op)) state_d = S_MEM_RD;
        else                     state_d = S_MEM_WR;
      end
      S_MEM_IND: begin
        mem_st = MEM_IND;
        if (complete_data) state_d = is_load(ex_op) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_st = MEM_RD;
        if (complete_data) begin
          {en_pc, en_fetch, en_dec, en_exe, en_wb} = 5'b11111;
          mem_exit = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_MEM_WR: begin
        mem_st = MEM_WR;
        if (complete_data) begin
          {en_pc, en_fetch, en_dec, en_exe} = 4'b1111;
          state_d = S_RUN;
        end
      end
      S_BR_EXEC: begin
        en_pc  = 1'b1;
        en_exe = 1'b1;
        en_wb  = 1'b1;
        br     = (ex_op == OP_JMP) ? 1'b1 : |(NZP & psr);
        // Refill from count 1: the slot at count 0 is the resolved fetch itself.
        state_d    = S_FILL;
        fill_cnt_d = 2'd1;
      end
      default: begin
        state_d    = S_FILL;
        fill_cnt_d = 2'd0;
      end
    endcase
  end

  lc3_bypass_unit u_bypass (
    .IR           (IR),
    .IR_Exec      (IR_Exec),
    .mem_exit     (mem_exit),
    .bypass_alu_1 (alu_1),
    .bypass_alu_2 (alu_2),
    .bypass_mem_1 (mem_1),
    .bypass_mem_2 (mem_2)
  );

  // Reset forces the idle output pattern while it is held.
  assign enable_updatePC  = ~reset & en_pc;
  assign enable_fetch     = ~reset & en_fetch;
  assign enable_decode    = ~reset & en_dec;
  assign enable_execute   = ~reset & en_exe;
  assign enable_writeback = ~reset & en_wb;
  assign br_taken         = ~reset & br;
  assign bypass_alu_1     = ~reset & alu_1;
  assign bypass_alu_2     = ~reset & alu_2;
  assign bypass_mem_1     = ~reset & mem_1;
  assign bypass_mem_2     = ~reset & mem_2;
  assign mem_state        = reset ? MEM_IDLE : mem_st;

endmodule

// File: tb/tb_lc3_pipeline_ctrl.sv
// Directed bench for lc3_pipeline_ctrl. Each cycle's observable outputs are
// packed as {en[pc,fetch,dec,exe,wb], br_taken, mem_state, alu1, alu2, mem1, mem2}.
module tb_lc3_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset, complete_instr, complete_data;
  logic [15:0] IR, IR_Exec, Instr_dout;
  logic [2:0]  NZP, psr;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, br_taken;
  logic [1:0]  mem_state;
  logic [11:0] obs, exp_v;
  int          n_pass = 0;
  int          n_total = 0;

  lc3_pipeline_ctrl dut (
    .clk(clk), .reset(reset), .complete_instr(complete_instr), .complete_data(complete_data),
    .IR(IR), .IR_Exec(IR_Exec), .Instr_dout(Instr_dout), .NZP(NZP), .psr(psr),
    .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch),
    .enable_decode(enable_decode), .enable_execute(enable_execute),
    .enable_writeback(enable_writeback),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
    .mem_state(mem_state), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  assign obs = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
                br_taken, mem_state, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; complete_instr = 1'b1;
    tick(); tick();
    exp_v = 12'b00000_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL reset_hold obs=%b exp=%b", obs, exp_v); else n_pass++;
    reset = 1'b0; #1;
    exp_v = 12'b11000_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL fill_c0 obs=%b exp=%b", obs, exp_v); else n_pass++;
    tick();
    exp_v = 12'b11100_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL fill_c1 obs=%b exp=%b", obs, exp_v); else n_pass++;
    complete_instr = 1'b0; #1;
    exp_v = 12'b00000_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL fill_istall obs=%b exp=%b", obs, exp_v); else n_pass++;
    tick(); complete_instr = 1'b1; #1;
    exp_v = 12'b11100_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL fill_c1_held obs=%b exp=%b", obs, exp_v); else n_pass++;
    tick();
    exp_v = 12'b11110_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL fill_c2 obs=%b exp=%b", obs, exp_v); else n_pass++;
    tick();
    exp_v = 12'b11111_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL fill_c3 obs=%b exp=%b", obs, exp_v); else n_pass++;
    tick();
    exp_v = 12'b11111_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL run_entry obs=%b exp=%b", obs, exp_v); else n_pass++;
    complete_instr = 1'b0; #1;
    exp_v = 12'b00000_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL run_istall obs=%b exp=%b", obs, exp_v); else n_pass++;
    complete_instr = 1'b1; #1;
  endtask

  task automatic test_ldi_wait();
    IR_Exec = 16'hA5FF; complete_data = 1'b0; #1;
    exp_v = 12'b00000_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL ldi_run obs=%b exp=%b", obs, exp_v); else n_pass++;
    tick();
    exp_v = 12'b00000_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL ldi_detect obs=%b exp=%b", obs, exp_v); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick(); complete_data = (i == 2); #1;
      exp_v = 12'b00000_0_01_0000; n_total++; if (obs !== exp_v) $display("FAIL ldi_ind%0d obs=%b exp=%b", i, obs, exp_v); else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      tick(); complete_data = 1'b0; #1;
      exp_v = 12'b00000_0_00_0000; n_total++; if (obs !== exp_v) $display("FAIL ldi_rd%0d obs=%b exp=%b", i, obs, exp_v); else n_pass++;
    end
    tick(); complete_data = 1'b1; #1;
    exp_v = 12'b11111_0_00_0000; n_total++; if (obs !== exp_v) $display("FAIL ldi_exit obs=%b exp=%b", obs, exp_v); else n_pass++;
    tick(); complete_data = 1'b0; IR_Exec = 16'hF025; #1;
    exp_v = 12'b11111_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL ldi_back_run obs=%b exp=%b", obs, exp_v); else n_pass++;
  endtask

  task automatic branch_case(input logic [15:0] ir_v, input logic [2:0] nzp_v,
                             input logic [2:0] psr_v, input logic taken);
    IR = ir_v; #1;
    exp_v = 12'b00011_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL br_bubble ir=%h obs=%b exp=%b", ir_v, obs, exp_v); else n_pass++;
    tick(); IR = 16'h2000; IR_Exec = ir_v; NZP = nzp_v; psr = psr_v; #1;
    exp_v = {5'b10011, taken, 2'b11, 4'b0000}; n_total++; if (obs !== exp_v) $display("FAIL br_exec ir=%h obs=%b exp=%b", ir_v, obs, exp_v); else n_pass++;
    tick(); IR_Exec = 16'hF025; NZP = 3'b000; psr = 3'b000; #1;
    exp_v = 12'b11100_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL br_refill1 ir=%h obs=%b exp=%b", ir_v, obs, exp_v); else n_pass++;
    tick();
    exp_v = 12'b11110_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL br_refill2 ir=%h obs=%b exp=%b", ir_v, obs, exp_v); else n_pass++;
    tick(); tick();
    exp_v = 12'b11111_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL br_run ir=%h obs=%b exp=%b", ir_v, obs, exp_v); else n_pass++;
  endtask

  task automatic test_branch();
    branch_case(16'h0E05, 3'b111, 3'b010, 1'b1);
    branch_case(16'h0E05, 3'b100, 3'b010, 1'b0);
    branch_case(16'hC080, 3'b000, 3'b000, 1'b1);
  endtask

  task automatic test_alu_forward();
    IR_Exec = 16'h1261; IR = 16'h1442; #1;
    exp_v = 12'b11111_0_11_1000; n_total++; if (obs !== exp_v) $display("FAIL alu_sr1 obs=%b exp=%b", obs, exp_v); else n_pass++;
    IR = 16'h1441; #1;
    exp_v = 12'b11111_0_11_1100; n_total++; if (obs !== exp_v) $display("FAIL alu_both obs=%b exp=%b", obs, exp_v); else n_pass++;
    IR = 16'h1461; #1;
    exp_v = 12'b11111_0_11_1000; n_total++; if (obs !== exp_v) $display("FAIL alu_imm obs=%b exp=%b", obs, exp_v); else n_pass++;
    IR = 16'h3200; #1;
    exp_v = 12'b11111_0_11_0100; n_total++; if (obs !== exp_v) $display("FAIL alu_st_src obs=%b exp=%b", obs, exp_v); else n_pass++;
    IR = 16'h2000; IR_Exec = 16'hF025; #1;
  endtask

  task automatic test_mem_forward();
    IR_Exec = 16'h66C0; IR = 16'h18C3; complete_data = 1'b0; #1;
    exp_v = 12'b00000_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL ldr_run obs=%b exp=%b", obs, exp_v); else n_pass++;
    tick(); tick();
    exp_v = 12'b00000_0_00_0000; n_total++; if (obs !== exp_v) $display("FAIL ldr_rd_wait obs=%b exp=%b", obs, exp_v); else n_pass++;
    tick(); complete_data = 1'b1; #1;
    exp_v = 12'b11111_0_00_0011; n_total++; if (obs !== exp_v) $display("FAIL ldr_exit_fwd obs=%b exp=%b", obs, exp_v); else n_pass++;
    tick(); complete_data = 1'b0; IR = 16'h2000; IR_Exec = 16'hF025; #1;
    exp_v = 12'b11111_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL ldr_back_run obs=%b exp=%b", obs, exp_v); else n_pass++;
  endtask

  task automatic test_store_reset();
    IR_Exec = 16'h3000; complete_data = 1'b1; #1;
    tick(); tick();
    exp_v = 12'b11110_0_10_0000; n_total++; if (obs !== exp_v) $display("FAIL st_exit obs=%b exp=%b", obs, exp_v); else n_pass++;
    tick(); complete_data = 1'b0; #1;
    exp_v = 12'b00000_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL st_redetect obs=%b exp=%b", obs, exp_v); else n_pass++;
    tick(); tick();
    exp_v = 12'b00000_0_10_0000; n_total++; if (obs !== exp_v) $display("FAIL st_wr_wait obs=%b exp=%b", obs, exp_v); else n_pass++;
    reset = 1'b1;
    tick();
    exp_v = 12'b00000_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL midop_reset obs=%b exp=%b", obs, exp_v); else n_pass++;
    reset = 1'b0; IR_Exec = 16'hF025; #1;
    exp_v = 12'b11000_0_11_0000; n_total++; if (obs !== exp_v) $display("FAIL post_reset_fill obs=%b exp=%b", obs, exp_v); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; complete_instr = 1'b1; complete_data = 1'b0;
    IR = 16'h2000; IR_Exec = 16'hF025; Instr_dout = 16'h0000;
    NZP = 3'b000; psr = 3'b000;
    test_reset();
    test_ldi_wait();
    test_branch();
    test_alu_forward();
    test_mem_forward();
    test_store_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
